// File: rtl/sz_ex.sv
// Immediate sign/zero-extension unit: forms a registered 32-bit operand from a 20-bit immediate field.
// Optional: define SZ_EX_ZERO_FLAG_EN to add a registered out_zero flag.
module sz_ex (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        sz_ex_sel,
    input  logic [1:0]  sz_ex_mode,
    input  logic [19:0] imm,
    output logic [31:0] sz_ex_out,
    output logic        out_valid
`ifdef SZ_EX_ZERO_FLAG_EN
    ,
    output logic        out_zero
`endif
);

    typedef enum logic [1:0] {
        STANDARD = 2'b00,
        BRANCH   = 2'b01,
        U_TYPE   = 2'b10,
        JAL      = 2'b11
    } mode_e;

    mode_e       mode;
    logic        ext;
    logic [31:0] f;

    assign mode = mode_e'(sz_ex_mode);

    // NOTE: every output of always_comb gets a default first so no path can infer a latch.
    always_comb begin
        ext = 1'b0;
        f   = 32'h0;
        unique case (mode)
            STANDARD: begin
                ext = sz_ex_sel & imm[11];
                f   = {{20{ext}}, imm[11:0]};
            end
            BRANCH: begin
                ext = sz_ex_sel & imm[11];
                f   = {{19{ext}}, imm[11:0], 1'b0};
            end
            U_TYPE: begin
                f   = {imm, 12'h000};
            end
            JAL: begin
                ext = sz_ex_sel & imm[19];
                f   = {{11{ext}}, imm, 1'b0};
            end
            default: f = 32'h0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sz_ex_out <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sz_ex_out <= f;
            end
        end
    end

`ifdef SZ_EX_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
        end else if (in_valid) begin
            out_zero <= (f == 32'h0);
        end
    end
`endif

endmodule

// File: tb/tb_sz_ex.sv
// Directed self-checking bench for sz_ex; expected values are hand-computed constants.
module tb_sz_ex;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        sz_ex_sel;
    logic [1:0]  sz_ex_mode;
    logic [19:0] imm;
    logic [31:0] sz_ex_out;
    logic        out_valid;
`ifdef SZ_EX_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [1:0] M_STD = 2'b00;
    localparam logic [1:0] M_BR  = 2'b01;
    localparam logic [1:0] M_U   = 2'b10;
    localparam logic [1:0] M_JAL = 2'b11;

    sz_ex dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .sz_ex_sel  (sz_ex_sel),
        .sz_ex_mode (sz_ex_mode),
        .imm        (imm),
        .sz_ex_out  (sz_ex_out),
        .out_valid  (out_valid)
`ifdef SZ_EX_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic s, input logic [19:0] i);
        in_valid   = v;
        sz_ex_mode = m;
        sz_ex_sel  = s;
        imm        = i;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse one request, check the result and that out_valid drops the cycle after.
    task automatic pulse(input string tag, input logic [1:0] m, input logic s,
                         input logic [19:0] i, input logic [31:0] exp);
        drive(1'b1, m, s, i);
        step();
        check({tag, "_out"}, sz_ex_out, exp);
        check({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        drive(1'b0, m, s, i);
        step();
        check({tag, "_vld_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_hold"}, sz_ex_out, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, M_STD, 1'b0, 20'h0);
        #12;
        rst_n = 1'b1;
        step();
        check("reset_out", sz_ex_out, 32'h0);
        check("reset_vld", {31'b0, out_valid}, 32'd0);

        // Load a nonzero value, then reset asynchronously mid-cycle with a request in flight.
        drive(1'b1, M_U, 1'b0, 20'h12345);
        step();
        check("pre_rst_out", sz_ex_out, 32'h12345000);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", sz_ex_out, 32'h0);
        check("async_rst_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, M_U, 1'b0, 20'h12345);
        step();
        check("post_rst_out", sz_ex_out, 32'h0);
        check("post_rst_vld", {31'b0, out_valid}, 32'd0);
        step();
        check("post_rst_vld2", {31'b0, out_valid}, 32'd0);

        pulse("std_z",   M_STD, 1'b0, 20'h00FFF, 32'h00000FFF);
        pulse("std_s",   M_STD, 1'b1, 20'h00FFF, 32'hFFFFFFFF);
        pulse("br_z",    M_BR,  1'b0, 20'h00FFF, 32'h00001FFE);
        pulse("br_s",    M_BR,  1'b1, 20'h00FFF, 32'hFFFFFFFE);
        pulse("br_hi",   M_BR,  1'b1, 20'hFF7FF, 32'h00000FFE);
        pulse("u_z",     M_U,   1'b0, 20'hFFFFF, 32'hFFFFF000);
        pulse("u_s",     M_U,   1'b1, 20'hFFFFF, 32'hFFFFF000);
        pulse("u_pat",   M_U,   1'b1, 20'h12345, 32'h12345000);
        pulse("jal_z",   M_JAL, 1'b0, 20'hFFFFF, 32'h001FFFFE);
        pulse("jal_s",   M_JAL, 1'b1, 20'hFFFFF, 32'hFFFFFFFE);
        pulse("jal_pos", M_JAL, 1'b1, 20'h7FFFF, 32'h000FFFFE);
        pulse("std_hi",  M_STD, 1'b1, 20'hFF7FF, 32'h000007FF);

        // Back-to-back requests.
        drive(1'b1, M_STD, 1'b1, 20'h00001);
        step();
        check("b2b_1_out", sz_ex_out, 32'h00000001);
        check("b2b_1_vld", {31'b0, out_valid}, 32'd1);
        drive(1'b1, M_JAL, 1'b1, 20'h80000);
        step();
        check("b2b_2_out", sz_ex_out, 32'hFFF00000);
        check("b2b_2_vld", {31'b0, out_valid}, 32'd1);
        drive(1'b0, M_U, 1'b0, 20'h0ABCD);
        step();
        check("hold_out", sz_ex_out, 32'hFFF00000);
        check("hold_vld", {31'b0, out_valid}, 32'd0);
        step();
        check("hold_out2", sz_ex_out, 32'hFFF00000);

`ifdef SZ_EX_ZERO_FLAG_EN
        drive(1'b1, M_STD, 1'b1, 20'h00000);
        step();
        check("zero_flag_set", {31'b0, out_zero}, 32'd1);
        drive(1'b1, M_STD, 1'b0, 20'h00001);
        step();
        check("zero_flag_clr", {31'b0, out_zero}, 32'd0);
        drive(1'b1, M_U, 1'b1, 20'hFF000);
        step();
        check("zero_flag_u_hi", {31'b0, out_zero}, 32'd0);
        drive(1'b1, M_STD, 1'b1, 20'hFF000);
        step();
        check("zero_flag_ign", {31'b0, out_zero}, 32'd1);
        drive(1'b0, M_STD, 1'b0, 20'h00005);
        step();
        check("zero_flag_hold", {31'b0, out_zero}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
